// File: rtl/bridge_sched_pkg.sv
// Shared types and default sizing for the bridge-buffer / matmul scheduler.
package bridge_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RESET,
    RUN,
    DRAIN,
    RELEASE
  } sched_state_t;

  localparam int NUM_HEADS       = 4;
  localparam int BLOCKS_PER_HEAD = 16;
  localparam int RST_CYCLES      = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr_i.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = IDX_W'((32'(ptr_i) + i) % N);
      if (!any_o && req_i[cand]) begin
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
        any_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/head_matmul_scheduler.sv
// Time-shares one matmul engine across per-head bridge buffers: arbitrates,
// sequences engine reset/enable, counts output blocks and releases each head.
module head_matmul_scheduler
  import bridge_sched_pkg::*;
#(
  parameter int NUM_HEADS       = bridge_sched_pkg::NUM_HEADS,
  parameter int BLOCKS_PER_HEAD = bridge_sched_pkg::BLOCKS_PER_HEAD,
  parameter int RST_CYCLES      = bridge_sched_pkg::RST_CYCLES,
  parameter int HEAD_IDX_W      = (NUM_HEADS > 1) ? $clog2(NUM_HEADS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_HEADS-1:0]  head_ready,
  input  logic                  acc_done_wrap,
  input  logic                  systolic_finish_wrap,
  output logic [NUM_HEADS-1:0]  head_grant,
  output logic [HEAD_IDX_W-1:0] head_sel,
  output logic [NUM_HEADS-1:0]  head_release,
  output logic                  mm_rst_n,
  output logic                  mm_reset_acc,
  output logic                  mm_en,
  output logic                  out_valid,
  output logic [HEAD_IDX_W-1:0] out_head,
  output logic                  busy
);

  localparam int BLK_W = $clog2(BLOCKS_PER_HEAD + 1);
  localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  sched_state_t          state_q, state_d;
  logic [RST_W-1:0]      rst_cnt_q, rst_cnt_d;
  logic [BLK_W-1:0]      blk_cnt_q, blk_cnt_d;
  logic [HEAD_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [NUM_HEADS-1:0]  head_grant_q, head_grant_d;
  logic [HEAD_IDX_W-1:0] head_sel_q, head_sel_d;
  logic [NUM_HEADS-1:0]  head_release_q, head_release_d;
  logic                  mm_rst_n_q, mm_rst_n_d;
  logic                  mm_reset_acc_q, mm_reset_acc_d;
  logic                  mm_en_q, mm_en_d;
  logic                  out_valid_q, out_valid_d;
  logic [HEAD_IDX_W-1:0] out_head_q, out_head_d;
  logic                  busy_q, busy_d;

  logic [NUM_HEADS-1:0]  arb_gnt;
  logic [HEAD_IDX_W-1:0] arb_idx;
  logic                  arb_any;

  rr_arbiter #(
    .N     (NUM_HEADS),
    .IDX_W (HEAD_IDX_W)
  ) u_arb (
    .req_i (head_ready),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  always_comb begin
    state_d        = state_q;
    rst_cnt_d      = rst_cnt_q;
    blk_cnt_d      = blk_cnt_q;
    rr_ptr_d       = rr_ptr_q;
    head_grant_d   = head_grant_q;
    head_sel_d     = head_sel_q;
    out_head_d     = out_head_q;
    head_release_d = '0;
    mm_rst_n_d     = 1'b0;
    mm_reset_acc_d = 1'b0;
    mm_en_d        = 1'b0;
    out_valid_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          state_d      = RESET;
          head_grant_d = arb_gnt;
          head_sel_d   = arb_idx;
          blk_cnt_d    = '0;
          rst_cnt_d    = '0;
        end
      end
      RESET: begin
        if (rst_cnt_q == RST_W'(RST_CYCLES - 1)) state_d = RUN;
        else rst_cnt_d = rst_cnt_q + 1'b1;
      end
      RUN: begin
        if (acc_done_wrap) begin
          out_valid_d = 1'b1;
          out_head_d  = head_sel_q;
          blk_cnt_d   = blk_cnt_q + 1'b1;
          if (blk_cnt_q == BLK_W'(BLOCKS_PER_HEAD - 1))
            state_d = systolic_finish_wrap ? RELEASE : DRAIN;
          else
            mm_reset_acc_d = 1'b1;
        end
      end
      DRAIN: begin
        if (systolic_finish_wrap) state_d = RELEASE;
      end
      RELEASE: begin
        state_d  = IDLE;
        rr_ptr_d = (32'(head_sel_q) == 32'(NUM_HEADS - 1)) ? '0 : head_sel_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    unique case (state_d)
      IDLE: begin
        head_grant_d = '0;
        head_sel_d   = '0;
      end
      RESET:       mm_reset_acc_d = 1'b1;
      RUN, DRAIN: begin
        mm_rst_n_d = 1'b1;
        mm_en_d    = 1'b1;
      end
      RELEASE: begin
        mm_rst_n_d     = 1'b1;
        head_release_d = head_grant_q;
      end
      default: ;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      rst_cnt_q      <= '0;
      blk_cnt_q      <= '0;
      rr_ptr_q       <= '0;
      head_grant_q   <= '0;
      head_sel_q     <= '0;
      head_release_q <= '0;
      mm_rst_n_q     <= 1'b0;
      mm_reset_acc_q <= 1'b0;
      mm_en_q        <= 1'b0;
      out_valid_q    <= 1'b0;
      out_head_q     <= '0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      rst_cnt_q      <= rst_cnt_d;
      blk_cnt_q      <= blk_cnt_d;
      rr_ptr_q       <= rr_ptr_d;
      head_grant_q   <= head_grant_d;
      head_sel_q     <= head_sel_d;
      head_release_q <= head_release_d;
      mm_rst_n_q     <= mm_rst_n_d;
      mm_reset_acc_q <= mm_reset_acc_d;
      mm_en_q        <= mm_en_d;
      out_valid_q    <= out_valid_d;
      out_head_q     <= out_head_d;
      busy_q         <= busy_d;
    end
  end

  assign head_grant   = head_grant_q;
  assign head_sel     = head_sel_q;
  assign head_release = head_release_q;
  assign mm_rst_n     = mm_rst_n_q;
  assign mm_reset_acc = mm_reset_acc_q;
  assign mm_en        = mm_en_q;
  assign out_valid    = out_valid_q;
  assign out_head     = out_head_q;
  assign busy         = busy_q;

endmodule
